seg7_to_bcd_reader: RTL and testbench
=====================================

Name: seg7_to_bcd_reader

Overview:
Reads an active-low 7-segment pattern from a display bus, using the same segment encoding our BCD-to-7-segment driver emits, and recovers the BCD digit.
- Synchronizes the segment lines and waits until the pattern is stable for STABLE_CYCLES cycles.
- Decodes the stable pattern once and presents it on a valid/ready output.
- Used in loopback self-test of the factorial display path and to read back driven digits.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold unchanged before it is decoded (legal range 1..255).
CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous, active-high, clears all state.
seg_in  input  7  segment lines {s6..s0}, active low (0 = lit); asynchronous to clk.
bcd_out  output  4  decoded digit; 4'b1111 when err_out=1.
err_out  output  1  qualified by valid_out: stable pattern is not a legal digit.
valid_out  output  1  bcd_out/err_out hold a result.
ready_in  input  1  consumer accepts the result while valid_out=1.
ovf_out  output  1  sticky: a new result overwrote an unaccepted one.

Behaviour:
- Reset (async assert, sync release). Outputs: bcd_out=4'b0000, err_out=0, valid_out=0, ovf_out=0. Internally: sync stages and last_pat=7'b1111111 (all off), counter=0, FSM=COUNT.
- Synchronizer: 2 flops on seg_in, giving seg_sync.
- Stability counter:
  - seg_sync != seg_prev (prior cycle's seg_sync): counter <= 0.
  - Otherwise counter increments, saturating at STABLE_CYCLES.
- Pattern table, listed as s0..s6 (leftmost = s0):
  - 0=0001000, 1=1011011, 2=0100010, 3=0010010, 4=1010001
  - 5=0010100, 6=0000100, 7=1011010, 8=0000000, 9=1010000
  - Any other pattern is illegal: bcd 4'b1111, err=1.
- FSM states: COUNT, REPORTED.
  - COUNT -> REPORTED when the counter reaches STABLE_CYCLES. That cycle: decode seg_sync, load bcd_out/err_out, set valid_out=1, last_pat <= seg_sync.
  - REPORTED -> COUNT on any seg_sync change, with counter cleared.
  - A pattern equal to last_pat that re-stabilizes after a glitch is reported again; every stabilization event is reported.
- Latency: seg_in changes at edge t, with no further change -> valid_out=1 after edge t+2+STABLE_CYCLES.
- Handshake:
  - valid_out=1 and ready_in=1 at a clock edge -> valid_out=0 next cycle.
  - bcd_out/err_out are held stable while valid_out=1 and no new event occurs.
- Simultaneous accept and new event in the same cycle: the new result loads, valid_out stays 1, ovf_out unchanged.
- New event while valid_out=1 and ready_in=0: the new result overwrites, ovf_out <= 1. ovf_out clears only on reset.
- ready_in while valid_out=0: ignored.
- Reset mid-count or mid-handshake: immediate return to reset values; an in-flight result is discarded.

Optional Feature:
Macro SEG7_BLANK_DETECT_EN.
- Defined: the all-off pattern 1111111 is not reported as a result; the FSM enters REPORTED with valid_out unchanged. A blank_out output (1 bit, reset 0) is added and mirrors "stable pattern is blank".
- Not defined: 1111111 is an ordinary illegal pattern (bcd 4'b1111, err_out=1), and blank_out does not exist.

Decomposition:
- Shared package seg7_pkg holds:
  - The ten 7-bit digit pattern constants.
  - SEG_BLANK = 7'b1111111.
  - BCD_ERR = 4'b1111.
  - FSM state encoding (COUNT=0, REPORTED=1).
- The display driver will also be moved to these constants.
- One sub-module: seg7_pattern_decode. It is combinational pattern-to-{bcd, err}, reused by the bench scoreboard. The top holds the synchronizer, counter, FSM and handshake.

Test Plan:
1. STABLE_CYCLES=4, ready_in=1, seg_in=0001000 applied after edge 10 -> valid_out=1 after edge 16 for exactly one cycle, bcd_out=0, err_out=0.
2. Sweep all ten patterns, each held 10 cycles, ready_in=1 -> ten results 0..9 in order, no err_out, ovf_out=0.
3. seg_in=1111111 (macro undefined) -> bcd_out=4'b1111, err_out=1. Macro defined -> no valid_out, blank_out=1.
4. seg_in=0010010 (3) toggles to 0000000 for 2 cycles, then returns to 3 -> no result for 8; 3 is reported a second time.
5. ready_in=0; digits 5 then 6 each stabilize -> bcd_out=6, valid_out=1, ovf_out=1. Raising ready_in one cycle -> valid_out=0, ovf_out stays 1.
6. rst asserted mid-count after pattern 7 has been stable 2 cycles -> outputs return to reset values at once. After release with 7 still applied, valid_out rises only after the full 2+STABLE_CYCLES cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment encoding for the BCD display driver and the
// read-back path. Patterns are on the bus as {s6..s0}, active low
// (0 = lit). The constants below are already in that bus order.
package seg7_pkg;

    localparam logic [6:0] SEG_PAT_0 = 7'b0001000;
    localparam logic [6:0] SEG_PAT_1 = 7'b1101101;
    localparam logic [6:0] SEG_PAT_2 = 7'b0100010;
    localparam logic [6:0] SEG_PAT_3 = 7'b0100100;
    localparam logic [6:0] SEG_PAT_4 = 7'b1000101;
    localparam logic [6:0] SEG_PAT_5 = 7'b0010100;
    localparam logic [6:0] SEG_PAT_6 = 7'b0010000;
    localparam logic [6:0] SEG_PAT_7 = 7'b0101101;
    localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9 = 7'b0000101;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit code reported for any pattern outside the table.
    localparam logic [3:0] BCD_ERR = 4'b1111;

    // Reader FSM encoding.
    localparam logic [0:0] ST_COUNT    = 1'b0;
    localparam logic [0:0] ST_REPORTED = 1'b1;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational map from an active-low 7-segment
// pattern ({s6..s0}) to its BCD digit. Unknown patterns give BCD_ERR
// with err_o set.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] bcd_o,
    output logic       err_o
);

    // Table lookup; anything not listed is flagged as an error.
    always_comb begin
        // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latch).
        bcd_o = BCD_ERR;
        err_o = 1'b1;
        case (pat_i)
            SEG_PAT_0: begin bcd_o = 4'd0; err_o = 1'b0; end
            SEG_PAT_1: begin bcd_o = 4'd1; err_o = 1'b0; end
            SEG_PAT_2: begin bcd_o = 4'd2; err_o = 1'b0; end
            SEG_PAT_3: begin bcd_o = 4'd3; err_o = 1'b0; end
            SEG_PAT_4: begin bcd_o = 4'd4; err_o = 1'b0; end
            SEG_PAT_5: begin bcd_o = 4'd5; err_o = 1'b0; end
            SEG_PAT_6: begin bcd_o = 4'd6; err_o = 1'b0; end
            SEG_PAT_7: begin bcd_o = 4'd7; err_o = 1'b0; end
            SEG_PAT_8: begin bcd_o = 4'd8; err_o = 1'b0; end
            SEG_PAT_9: begin bcd_o = 4'd9; err_o = 1'b0; end
            default:   begin bcd_o = BCD_ERR; err_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_to_bcd_reader.sv
// seg7_to_bcd_reader: synchronizes an asynchronous active-low segment bus,
// waits for the pattern to hold for STABLE_CYCLES cycles, decodes it once
// and offers the digit on a valid/ready output. A result overwritten before
// acceptance sets the sticky ovf_out.
// Optional: define SEG7_BLANK_DETECT_EN to suppress results for the
// all-off pattern and add the blank_out indication.
module seg7_to_bcd_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic [3:0] bcd_out,
    output logic       err_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       ovf_out
`ifdef SEG7_BLANK_DETECT_EN
    ,
    output logic       blank_out
`endif
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    logic [6:0]       sync1_q;
    logic [6:0]       seg_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic [6:0]       last_pat_q, last_pat_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             report;
    logic             load;
    logic [3:0]       dec_bcd;
    logic             dec_err;

    // Two-flop synchronizer; both stages start at the all-off pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= SEG_BLANK;
            seg_sync_q <= SEG_BLANK;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1_q    <= seg_in;
            seg_sync_q <= sync1_q;
        end
    end

    // Stability counter and FSM. The change test compares the value seg_sync
    // is about to take with its current value, so the counter and seg_sync
    // move on the same edge and the counter equals the number of edges
    // seg_sync has held its present value.
    always_comb begin
        cnt_d      = cnt_q;
        state_d    = state_q;
        last_pat_d = last_pat_q;
        report     = 1'b0;
        if (sync1_q != seg_sync_q) begin
            cnt_d   = '0;
            state_d = ST_COUNT;
        end else begin
            if (cnt_q != STABLE_CNT) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((state_q == ST_COUNT) && (cnt_d == STABLE_CNT)) begin
                report     = 1'b1;
                state_d    = ST_REPORTED;
                last_pat_d = seg_sync_q;
            end
        end
    end

    // The decoder watches the pattern being latched, so on a report it sees
    // the freshly stabilized value.
    seg7_pattern_decode u_decode (
        .pat_i (last_pat_d),
        .bcd_o (dec_bcd),
        .err_o (dec_err)
    );

`ifdef SEG7_BLANK_DETECT_EN
    // A blank display is tracked but never offered as a result.
    assign load      = report && (seg_sync_q != SEG_BLANK);
    assign blank_out = (state_q == ST_REPORTED) && (last_pat_q == SEG_BLANK);
`else
    assign load = report;
`endif

    // Output handshake: a new result always wins over an accept, and
    // overwriting an unaccepted result raises the sticky overflow flag.
    always_comb begin
        bcd_d   = bcd_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (load) begin
            bcd_d   = dec_bcd;
            err_d   = dec_err;
            valid_d = 1'b1;
            if (valid_q && !ready_in) begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    // State registers for counter, FSM, last pattern and the result port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            state_q    <= ST_COUNT;
            last_pat_q <= SEG_BLANK;
            bcd_q      <= 4'b0000;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            last_pat_q <= last_pat_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign err_out   = err_q;
    assign valid_out = valid_q;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_seg7_to_bcd_reader.sv
// Testbench for seg7_to_bcd_reader. Stimulus pushes expected results into a
// queue; a monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_seg7_to_bcd_reader;

    localparam int STABLE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic [3:0] bcd_out;
    logic       err_out;
    logic       valid_out;
    logic       ready_in;
    logic       ovf_out;
`ifdef SEG7_BLANK_DETECT_EN
    logic       blank_out;
`endif

    always #5 clk = ~clk;

    seg7_to_bcd_reader #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .ovf_out   (ovf_out)
`ifdef SEG7_BLANK_DETECT_EN
        ,
        .blank_out (blank_out)
`endif
    );

    typedef struct packed {
        logic [3:0] bcd;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_res  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Patterns written in table order s0..s6 (MSB of the literal is s0).
    function automatic logic [6:0] table_pat(input int d);
        case (d)
            0: table_pat = 7'b0001000;
            1: table_pat = 7'b1011011;
            2: table_pat = 7'b0100010;
            3: table_pat = 7'b0010010;
            4: table_pat = 7'b1010001;
            5: table_pat = 7'b0010100;
            6: table_pat = 7'b0000100;
            7: table_pat = 7'b1011010;
            8: table_pat = 7'b0000000;
            default: table_pat = 7'b1010000;
        endcase
    endfunction

    // Reorder a table-order pattern onto the {s6..s0} bus.
    function automatic logic [6:0] to_bus(input logic [6:0] t);
        logic [6:0] b;
        for (int i = 0; i < 7; i++) b[i] = t[6-i];
        return b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [3:0] bcd, input logic err);
        exp_t e;
        e.bcd = bcd;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: a handshake completes on the next edge whenever both are high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1 && ready_in === 1'b1) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected result #%0d: got bcd=%h err=%b, expected none",
                             n_res, bcd_out, err_out);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result #%0d bcd", n_res), 32'(bcd_out), 32'(e.bcd));
                    check($sformatf("result #%0d err", n_res), 32'(err_out), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;

        rst      = 1'b1;
        seg_in   = 7'b1111111;
        ready_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset bcd_out",   32'(bcd_out),   32'h0);
        check("reset err_out",   32'(err_out),   32'h0);
        check("reset valid_out", 32'(valid_out), 32'h0);
        check("reset ovf_out",   32'(ovf_out),   32'h0);
`ifdef SEG7_BLANK_DETECT_EN
        check("reset blank_out", 32'(blank_out), 32'h0);
`else
        // The idle blank bus stabilizes after release and reads as illegal.
        expect_result(4'hF, 1'b1);
`endif
        rst = 1'b0;

        // Test 1: digit 0 applied after edge 10, result after edge 16.
        tick(10);
        seg_in = to_bus(table_pat(0));
        expect_result(4'd0, 1'b0);
        lat = -1;
        for (int k = 10; k <= 40; k++) begin
            @(negedge clk);
            if (valid_out) begin
                lat = k;
                break;
            end
        end
        check("t1 valid edge", 32'(lat), 32'd16);
        @(negedge clk);
        check("t1 valid one cycle", 32'(valid_out), 32'h0);
        tick(3);

        // Test 3: blank pattern.
        seg_in = 7'b1111111;
`ifdef SEG7_BLANK_DETECT_EN
        tick(10);
        check("t3 blank_out", 32'(blank_out), 32'h1);
        check("t3 blank no valid", 32'(valid_out), 32'h0);
`else
        expect_result(4'hF, 1'b1);
        tick(10);
`endif

        // Test 2: sweep all ten digits.
        for (int d = 0; d < 10; d++) begin
            seg_in = to_bus(table_pat(d));
            expect_result(4'(d), 1'b0);
            tick(10);
        end
        check("t2 ovf_out", 32'(ovf_out), 32'h0);

        // Test 4: 3, two-cycle glitch to 8, back to 3.
        seg_in = to_bus(table_pat(3));
        expect_result(4'd3, 1'b0);
        tick(10);
        seg_in = to_bus(table_pat(8));
        tick(2);
        seg_in = to_bus(table_pat(3));
        expect_result(4'd3, 1'b0);
        tick(10);

        // Test 5: consumer stalled, 5 then 6.
        ready_in = 1'b0;
        seg_in = to_bus(table_pat(5));
        tick(10);
        check("t5 first valid", 32'(valid_out), 32'h1);
        check("t5 first bcd",   32'(bcd_out),   32'd5);
        check("t5 first ovf",   32'(ovf_out),   32'h0);
        seg_in = to_bus(table_pat(6));
        tick(10);
        check("t5 second valid", 32'(valid_out), 32'h1);
        check("t5 second bcd",   32'(bcd_out),   32'd6);
        check("t5 second ovf",   32'(ovf_out),   32'h1);
        expect_result(4'd6, 1'b0);
        ready_in = 1'b1;
        tick(1);
        ready_in = 1'b0;
        @(negedge clk);
        check("t5 valid after accept", 32'(valid_out), 32'h0);
        check("t5 ovf sticky",         32'(ovf_out),   32'h1);
        tick(1);
        ready_in = 1'b1;

        // Test 6: reset after 7 has been stable two cycles.
        seg_in = to_bus(table_pat(7));
        tick(4);
        rst = 1'b1;
        #1;
        check("t6 reset valid", 32'(valid_out), 32'h0);
        check("t6 reset bcd",   32'(bcd_out),   32'h0);
        check("t6 reset err",   32'(err_out),   32'h0);
        check("t6 reset ovf",   32'(ovf_out),   32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_result(4'd7, 1'b0);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (valid_out) begin
                lat = k;
                break;
            end
        end
        check("t6 edges to valid", 32'(lat), 32'(2 + STABLE_CYCLES));
        tick(5);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
